// File: rtl/btn_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// btn_conditioner_pkg
// Shared definitions for the button conditioner: the per-channel FSM state
// encoding, the default parameter values and a counter-width helper.
// -----------------------------------------------------------------------------
package btn_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // released and stable
        ST_DEB_P = 2'd1,   // candidate press, counting stable high ticks
        ST_HELD  = 2'd2,   // accepted press, auto-repeat may run
        ST_DEB_R = 2'd3    // candidate release, counting stable low ticks
    } btn_state_t;

    localparam int DEF_N_BTN       = 5;
    localparam int DEF_TICK_DIV    = 50000;
    localparam int DEF_DEB_TICKS   = 10;
    localparam int DEF_REP_DELAY   = 400;
    localparam int DEF_REP_RATE    = 100;
    localparam int DEF_SYNC_STAGES = 2;

    // Bits needed to hold values 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// -----------------------------------------------------------------------------
// btn_channel
// One button channel: input synchroniser, debounce FSM and auto-repeat.
// The FSM only advances on cycles where tick is high; press/release_pulse
// are registered so they appear for one clock in the cycle after that tick.
//
// Ports
//   clock          single clock
//   reset          asynchronous, active-high
//   tick           prescaler strobe from the parent
//   btn_raw        unsynchronised, active-high button level
//   rep_en         auto-repeat enable (synchronous)
//   level          debounced button state
//   press          one-cycle pulse on accepted press and on each repeat
//   release_pulse  one-cycle pulse on accepted release
//                  (`release` is a SystemVerilog keyword, hence the name)
// -----------------------------------------------------------------------------
module btn_channel
    import btn_conditioner_pkg::*;
#(
    parameter int DEB_TICKS   = DEF_DEB_TICKS,
    parameter int REP_DELAY   = DEF_REP_DELAY,
    parameter int REP_RATE    = DEF_REP_RATE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    input  logic rep_en,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int CNT_W  = cnt_width(DEB_TICKS);
    localparam int RCNT_W = cnt_width((REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  DEB_LIM   = CNT_W'(DEB_TICKS);
    localparam logic [RCNT_W-1:0] RCNT_ONE  = RCNT_W'(1);
    localparam logic [RCNT_W-1:0] DELAY_LIM = RCNT_W'(REP_DELAY);
    localparam logic [RCNT_W-1:0] RATE_LIM  = RCNT_W'(REP_RATE);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   s;

    btn_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx, cnt_inc;
    logic [RCNT_W-1:0] rcnt, rcnt_nx, rcnt_inc;
    logic              rep_phase, rep_phase_nx;
    logic              level_nx, press_nx, release_nx;
    logic              rep_hit;

    // Synchroniser stage: btn_raw is never used before the last flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign s        = sync_p[SYNC_STAGES-1];
    assign cnt_inc  = cnt + CNT_ONE;
    assign rcnt_inc = rcnt + RCNT_ONE;

    // rcnt counts up to REP_DELAY before the first repeat (rep_phase=0),
    // then wraps every REP_RATE ticks (rep_phase=1).
    assign rep_hit = rep_phase ? (rcnt_inc == RATE_LIM) : (rcnt_inc == DELAY_LIM);

    // FSM / output register stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            rcnt          <= '0;
            rep_phase     <= 1'b0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            rcnt          <= rcnt_nx;
            rep_phase     <= rep_phase_nx;
            level         <= level_nx;
            press         <= press_nx;
            release_pulse <= release_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rcnt_nx      = rcnt;
        rep_phase_nx = rep_phase;
        level_nx     = level;
        press_nx     = 1'b0;
        release_nx   = 1'b0;

        if (tick) begin
            unique case (state)
                ST_IDLE: begin
                    if (s) begin
                        state_nx = ST_DEB_P;
                        cnt_nx   = CNT_ONE;
                    end
                end
                ST_DEB_P: begin
                    if (!s) begin
                        state_nx = ST_IDLE;
                    end else if (cnt_inc >= DEB_LIM) begin
                        state_nx     = ST_HELD;
                        level_nx     = 1'b1;
                        press_nx     = 1'b1;
                        rcnt_nx      = '0;
                        rep_phase_nx = 1'b0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!s) begin
                        state_nx = ST_DEB_R;
                        cnt_nx   = CNT_ONE;
                    end else if (!rep_en) begin
                        // Repeat disabled: hold the wait at its start so that
                        // re-enabling restarts the full REP_DELAY.
                        rcnt_nx      = '0;
                        rep_phase_nx = 1'b0;
                    end else if (rep_hit) begin
                        press_nx     = 1'b1;
                        rcnt_nx      = '0;
                        rep_phase_nx = 1'b1;
                    end else begin
                        rcnt_nx = rcnt_inc;
                    end
                end
                ST_DEB_R: begin
                    // A bounce back high resumes HELD with rcnt untouched.
                    if (s) begin
                        state_nx = ST_HELD;
                    end else if (cnt_inc >= DEB_LIM) begin
                        state_nx   = ST_IDLE;
                        level_nx   = 1'b0;
                        release_nx = 1'b1;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
// Debounces N_BTN push buttons with optional per-channel auto-repeat.
// A shared prescaler produces the sample tick; each channel is an
// independent btn_channel instance.
//
// Ports
//   clock          single clock
//   reset          asynchronous, active-high
//   btn_raw        [N_BTN] unsynchronised, active-high button levels
//   rep_en         [N_BTN] per-channel auto-repeat enable
//   level          [N_BTN] debounced button state
//   press          [N_BTN] one-cycle pulse on press and on each repeat
//   release_pulse  [N_BTN] one-cycle pulse on release
//                  (`release` is a SystemVerilog keyword, hence the name)
//   tick           one-cycle prescaler pulse, every TICK_DIV clocks
// -----------------------------------------------------------------------------
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN       = DEF_N_BTN,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int DEB_TICKS   = DEF_DEB_TICKS,
    parameter int REP_DELAY   = DEF_REP_DELAY,
    parameter int REP_RATE    = DEF_REP_RATE,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_BTN-1:0] rep_en,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse,
    output logic             tick
);

    localparam int              PRE_W    = cnt_width(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] pre_cnt;

    // tick decodes the terminal count, so it is high exactly in the cycle
    // where the prescaler sits at TICK_DIV-1 and is 0 throughout reset.
    assign tick = (pre_cnt == PRE_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_ONE;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .DEB_TICKS   (DEB_TICKS),
            .REP_DELAY   (REP_DELAY),
            .REP_RATE    (REP_RATE),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_channel (
            .clock         (clock),
            .reset         (reset),
            .tick          (tick),
            .btn_raw       (btn_raw[i]),
            .rep_en        (rep_en[i]),
            .level         (level[i]),
            .press         (press[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 5, number of independent button channels (right, left, up, down, middle).
REQ-002 SHALL have parameter TICK_DIV, default 50000, clock cycles per sample tick (1 ms at 50 MHz); legal range 2 and above.
REQ-003 SHALL have parameter DEB_TICKS, default 10, consecutive stable ticks required to accept a level change.
REQ-004 SHALL have parameters REP_DELAY, default 400, and REP_RATE, default 100, both in ticks, for auto-repeat.
REQ-005 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth; legal range 2 and above.
REQ-006 clock  input  1  single clock for the whole block.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 btn_raw  input  N_BTN  unsynchronised, active-high button levels.
REQ-009 rep_en  input  N_BTN  per-channel auto-repeat enable, synchronous to clock.
REQ-010 level  output  N_BTN  debounced button state.
REQ-011 press  output  N_BTN  one-cycle pulse on an accepted press and on each repeat.
REQ-012 release  output  N_BTN  one-cycle pulse on an accepted release.
REQ-013 tick  output  1  one-cycle prescaler pulse, exported for game timing.

Function
REQ-014 Prescaler SHALL count 0 to TICK_DIV-1, wrap to 0, and assert tick for exactly the cycle in which the count equals TICK_DIV-1.
REQ-015 Each btn_raw bit SHALL pass through SYNC_STAGES flops before any use; the synchronised value is s.
REQ-016 Each channel SHALL run its own FSM with states IDLE, DEB_P, HELD, DEB_R; the FSM SHALL advance only on tick cycles.
REQ-017 IDLE: on s=1 the FSM SHALL go to DEB_P with cnt=1.
REQ-018 DEB_P: on s=0 the FSM SHALL return to IDLE; otherwise cnt SHALL increment, and on reaching DEB_TICKS the FSM SHALL go to HELD, set level=1, pulse press, and clear rcnt.
REQ-019 HELD: on s=0 the FSM SHALL go to DEB_R with cnt=1; otherwise, if rep_en, rcnt SHALL increment and press SHALL pulse when rcnt reaches REP_DELAY, then every REP_RATE ticks after that.
REQ-020 DEB_R: on s=1 the FSM SHALL return to HELD, keeping level=1 and the repeat phase unchanged; on reaching DEB_TICKS it SHALL go to IDLE, set level=0, and pulse release.
REQ-021 Dropping rep_en in HELD SHALL freeze and clear rcnt with no further repeats; raising it again SHALL restart the REP_DELAY wait.
REQ-022 press and release SHALL be registered and asserted for exactly one clock cycle, aligned to the cycle after the tick.
REQ-023 press and release for the same channel SHALL never both assert in one cycle; channels SHALL be fully independent.
REQ-024 Counter widths SHALL be computed from the parameters so they never overflow; rcnt SHALL saturate-wrap within REP_RATE.
REQ-025 A glitch shorter than DEB_TICKS ticks SHALL produce no output change.

Reset
REQ-026 While reset is high, the prescaler, all counters, and the synchroniser flops SHALL be 0, the FSMs SHALL be in IDLE, and level, press, release, and tick SHALL all be 0.
REQ-027 Reset mid-press SHALL drop level immediately, with no release pulse; after reset deassertion, a still-held button SHALL be re-debounced from IDLE.

Structure
REQ-028 The FSM state encoding and the default parameter values SHALL live in the shared game package.
REQ-029 The per-channel logic SHALL be a single sub-module, btn_channel, instantiated N_BTN times by a generate loop; the prescaler and tick SHALL stay in the parent.

Verification (TICK_DIV=4, DEB_TICKS=3, REP_DELAY=5, REP_RATE=2)
REQ-030 Clean press on bit0, held for 20 ticks -> level[0] rises 3 ticks after the sync latency; a single press pulse; no repeat.
REQ-031 Same press with rep_en[0]=1 -> press pulses at 0, 5, 7, 9, ... ticks after the accepted press.
REQ-032 A 2-tick pulse on bit1 -> level, press, and release stay 0 throughout.
REQ-033 A 1-tick bounce low during HELD -> no release; level stays 1.
REQ-034 Simultaneous press on all 5 channels -> 5 press pulses in the same cycle.
REQ-035 Reset asserted while level[2]=1 -> level drops asynchronously with no release pulse; after deassertion, the held button is re-accepted 3 ticks later.
